// File: rtl/wb_interconnect_reg.sv
// Registered Wishbone address decoder/router with error responses and sticky error status.
// Define WB_IC_TIMEOUT_EN to enable the per-transaction timeout watchdog.
module wb_interconnect_reg #(
   parameter int          NUM_TEAMS      = 12,
   parameter int          TIMEOUT_CYCLES = 256,
   parameter int          TIMEOUT_W      = 16,
   parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
   input  logic                        clk,
   input  logic                        nrst,
   input  logic                        wbs_cyc_i,
   input  logic                        wbs_stb_i,
   input  logic [31:0]                 wbs_adr_i,
   output logic                        wbs_ack_o,
   output logic [31:0]                 wbs_dat_o,
   output logic [NUM_TEAMS:1]          designs_stb,
   output logic                        la_control_stb,
   output logic                        gpio_control_stb,
   output logic [31:0]                 adr_truncated,
   input  logic [NUM_TEAMS:1][31:0]    designs_dat_o,
   input  logic [31:0]                 la_control_dat_o,
   input  logic [31:0]                 gpio_control_dat_o,
   input  logic [NUM_TEAMS:1]          designs_ack_o,
   input  logic                        la_control_ack_o,
   input  logic                        gpio_control_ack_o,
   input  logic                        err_clr,
   output logic                        unmapped_err,
   output logic                        timeout_err
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t             state;
   logic [NUM_TEAMS:1] dec_team_stb;
   logic               dec_la;
   logic               dec_gpio;
   logic               dec_mapped;
   logic               sel_ack;
   logic [31:0]        sel_dat;

`ifdef WB_IC_TIMEOUT_EN
   localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
   logic [TIMEOUT_W-1:0] cnt;
`else
   logic [TIMEOUT_W-1:0] unused_timeout_cfg;
   assign unused_timeout_cfg = TIMEOUT_W'(TIMEOUT_CYCLES);
   assign timeout_err        = 1'b0;
`endif

   always_comb begin
      dec_team_stb = '0;
      for (int unsigned i = 1; i <= NUM_TEAMS; i++)
         dec_team_stb[i] = (wbs_adr_i[31:24] == 8'h30) && (wbs_adr_i[23:16] == 8'(i));
      dec_la     = (wbs_adr_i[31:16] == 16'h3100);
      dec_gpio   = (wbs_adr_i[31:16] == 16'h3200);
      dec_mapped = (|dec_team_stb) | dec_la | dec_gpio;
   end

   // The registered strobes double as the latched target select, so only
   // the selected slave's ack and data can ever reach the master.
   always_comb begin
      sel_ack = (la_control_ack_o & la_control_stb) | (gpio_control_ack_o & gpio_control_stb);
      sel_dat = ({32{la_control_stb}} & la_control_dat_o) |
                ({32{gpio_control_stb}} & gpio_control_dat_o);
      for (int unsigned i = 1; i <= NUM_TEAMS; i++) begin
         sel_ack = sel_ack | (designs_ack_o[i] & designs_stb[i]);
         sel_dat = sel_dat | (designs_dat_o[i] & {32{designs_stb[i]}});
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state            <= S_IDLE;
         designs_stb      <= '0;
         la_control_stb   <= 1'b0;
         gpio_control_stb <= 1'b0;
         wbs_ack_o        <= 1'b0;
         wbs_dat_o        <= '0;
         adr_truncated    <= '0;
         unmapped_err     <= 1'b0;
`ifdef WB_IC_TIMEOUT_EN
         cnt              <= '0;
         timeout_err      <= 1'b0;
`endif
      end else begin
         wbs_ack_o <= 1'b0;
         // Clear first; a set later in this block overrides it.
         if (err_clr) begin
            unmapped_err <= 1'b0;
`ifdef WB_IC_TIMEOUT_EN
            timeout_err  <= 1'b0;
`endif
         end
         case (state)
            S_IDLE: begin
               if (wbs_cyc_i && wbs_stb_i) begin
                  adr_truncated <= {16'h0000, wbs_adr_i[15:0]};
                  if (dec_mapped) begin
                     designs_stb      <= dec_team_stb;
                     la_control_stb   <= dec_la;
                     gpio_control_stb <= dec_gpio;
                     state            <= S_WAIT;
                  end else begin
                     wbs_ack_o    <= 1'b1;
                     wbs_dat_o    <= ERR_DATA;
                     unmapped_err <= 1'b1;
                     state        <= S_RESP;
                  end
               end
            end
            S_WAIT: begin
               if (!wbs_cyc_i) begin
                  designs_stb      <= '0;
                  la_control_stb   <= 1'b0;
                  gpio_control_stb <= 1'b0;
                  state            <= S_IDLE;
`ifdef WB_IC_TIMEOUT_EN
                  cnt              <= '0;
`endif
               end else if (sel_ack) begin
                  designs_stb      <= '0;
                  la_control_stb   <= 1'b0;
                  gpio_control_stb <= 1'b0;
                  wbs_ack_o        <= 1'b1;
                  wbs_dat_o        <= sel_dat;
                  state            <= S_RESP;
               end
`ifdef WB_IC_TIMEOUT_EN
               else if (cnt == CNT_LAST) begin
                  designs_stb      <= '0;
                  la_control_stb   <= 1'b0;
                  gpio_control_stb <= 1'b0;
                  wbs_ack_o        <= 1'b1;
                  wbs_dat_o        <= ERR_DATA;
                  timeout_err      <= 1'b1;
                  state            <= S_RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
`endif
            end
            S_RESP: begin
               state <= S_IDLE;
`ifdef WB_IC_TIMEOUT_EN
               cnt   <= '0;
`endif
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
